// File: rtl/clint_pkg.sv
// clint_pkg: register offsets, FSM state type and reset constants shared by the clint block.
// Byte-strobe merge helper used by every writable register.
package clint_pkg;

  localparam logic [15:0] CLINT_MSIP        = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
  localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
  localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
  localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

  localparam logic [63:0] CLINT_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic {
    CLINT_S_IDLE = 1'b0,
    CLINT_S_RESP = 1'b1
  } clint_state_e;

  function automatic logic [31:0] merge_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_val;
    for (int unsigned i = 0; i < 4; i++) begin
      if (wstrb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_prescaler.sv
// clint_prescaler: free-running divide counter; tick is high for one cycle
// each time the count wraps from TICK_DIV-1 back to 0.
module clint_prescaler #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned     CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CNT_MAX);
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/clint.sv
// clint: mtime/mtimecmp/msip behind a single-outstanding request/response port.
// Define CLINT_MSIP_EN to implement msip at offset 0x0000; otherwise that offset errors.
module clint
  import clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mti_pending,
  output logic              msi_pending
);

  clint_state_e state_q, state_d;
  logic [63:0]  mtime_q, mtime_d;
  logic [63:0]  mtimecmp_q, mtimecmp_d;
  logic [31:0]  rdata_q, rdata_d;
  logic         err_q, err_d;
  logic         mti_q, mti_d;
  logic         tick;
  logic         sel_msip, sel_cmp_lo, sel_cmp_hi, sel_mtime_lo, sel_mtime_hi;
  logic         mapped;
  logic [31:0]  rd_mux;

  clint_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  assign sel_cmp_lo   = (req_addr == ADDR_W'(CLINT_MTIMECMP_LO));
  assign sel_cmp_hi   = (req_addr == ADDR_W'(CLINT_MTIMECMP_HI));
  assign sel_mtime_lo = (req_addr == ADDR_W'(CLINT_MTIME_LO));
  assign sel_mtime_hi = (req_addr == ADDR_W'(CLINT_MTIME_HI));

`ifdef CLINT_MSIP_EN
  logic msip_q, msip_d;
  assign sel_msip    = (req_addr == ADDR_W'(CLINT_MSIP));
  assign msi_pending = msip_q;

  always_ff @(posedge clk) begin
    if (!rst_n) msip_q <= 1'b0;
    else        msip_q <= msip_d;
  end
`else
  assign sel_msip    = 1'b0;
  assign msi_pending = 1'b0;
`endif

  assign mapped = (req_addr[1:0] == 2'b00) &&
                  (sel_msip || sel_cmp_lo || sel_cmp_hi || sel_mtime_lo || sel_mtime_hi);

  always_comb begin
    rd_mux = '0;
    if (sel_cmp_lo)   rd_mux = mtimecmp_q[31:0];
    if (sel_cmp_hi)   rd_mux = mtimecmp_q[63:32];
    if (sel_mtime_lo) rd_mux = mtime_q[31:0];
    if (sel_mtime_hi) rd_mux = mtime_q[63:32];
`ifdef CLINT_MSIP_EN
    if (sel_msip)     rd_mux = {31'b0, msip_q};
`endif
  end

  always_comb begin
    state_d    = state_q;
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    mti_d      = (mtime_q >= mtimecmp_q);
    req_ready  = 1'b0;
`ifdef CLINT_MSIP_EN
    msip_d     = msip_q;
`endif
    unique case (state_q)
      CLINT_S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = CLINT_S_RESP;
          err_d   = !mapped;
          rdata_d = '0;
          if (mapped && !req_we) rdata_d = rd_mux;
          // A software write to an mtime half overrides the tick: the other half
          // keeps its value with no carry, and the increment is simply dropped.
          if (mapped && req_we) begin
            if (sel_cmp_lo)
              mtimecmp_d[31:0]  = merge_wstrb(mtimecmp_q[31:0], req_wdata, req_wstrb);
            if (sel_cmp_hi)
              mtimecmp_d[63:32] = merge_wstrb(mtimecmp_q[63:32], req_wdata, req_wstrb);
            if (sel_mtime_lo)
              mtime_d = {mtime_q[63:32], merge_wstrb(mtime_q[31:0], req_wdata, req_wstrb)};
            if (sel_mtime_hi)
              mtime_d = {merge_wstrb(mtime_q[63:32], req_wdata, req_wstrb), mtime_q[31:0]};
`ifdef CLINT_MSIP_EN
            if (sel_msip && req_wstrb[0]) msip_d = req_wdata[0];
`endif
          end
        end
      end
      CLINT_S_RESP: begin
        state_d = CLINT_S_IDLE;
      end
      default: state_d = CLINT_S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= CLINT_S_IDLE;
      mtime_q    <= '0;
      mtimecmp_q <= CLINT_MTIMECMP_RST;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      mti_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      mti_q      <= mti_d;
    end
  end

  assign resp_valid  = (state_q == CLINT_S_RESP);
  assign resp_rdata  = rdata_q;
  assign resp_err    = err_q;
  assign mti_pending = mti_q;

endmodule

// File: tb/tb_clint.sv
// tb_clint: directed self-checking bench; instance 0 runs TICK_DIV=1, instance 1 TICK_DIV=3.
// Expected values are hand-derived from edge counts since reset release.
module tb_clint;

  logic        clk;
  logic        rst_n;
  logic        req_valid   [2];
  logic        req_ready   [2];
  logic        req_we      [2];
  logic [15:0] req_addr    [2];
  logic [31:0] req_wdata   [2];
  logic [3:0]  req_wstrb   [2];
  logic        resp_valid  [2];
  logic [31:0] resp_rdata  [2];
  logic        resp_err    [2];
  logic        mti_pending [2];
  logic        msi_pending [2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rel      = 0;

`ifdef CLINT_MSIP_EN
  localparam bit MSIP_EN = 1'b1;
`else
  localparam bit MSIP_EN = 1'b0;
`endif

  clint #(.TICK_DIV(1), .ADDR_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
    .mti_pending(mti_pending[0]), .msi_pending(msi_pending[0])
  );

  clint #(.TICK_DIV(3), .ADDR_W(16)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
    .mti_pending(mti_pending[1]), .msi_pending(msi_pending[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Called at #1 after a posedge with the DUT idle; returns likewise, two edges later.
  task automatic access(input int d, input logic we, input logic [15:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb,
                        output logic [31:0] rdata, output logic err);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_wstrb[d] = wstrb;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    check("resp_valid", 64'(resp_valid[d]), 64'd1);
    rdata = resp_rdata[d];
    err   = resp_err[d];
    @(posedge clk); #1;
  endtask

  task automatic wr(input int d, input logic [15:0] addr, input logic [31:0] wdata,
                    input logic [3:0] wstrb);
    logic [31:0] rd;
    logic        er;
    access(d, 1'b1, addr, wdata, wstrb, rd, er);
    check("wr_err", 64'(er), 64'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;

    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0;
      req_wdata[i] = '0;   req_wstrb[i] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready",  64'(req_ready[0]),   64'd1);
    check("rst_resp_valid", 64'(resp_valid[0]),  64'd0);
    check("rst_rdata",      64'(resp_rdata[0]),  64'd0);
    check("rst_err",        64'(resp_err[0]),    64'd0);
    check("rst_mti",        64'(mti_pending[0]), 64'd0);
    check("rst_msi",        64'(msi_pending[0]), 64'd0);

    rst_n = 1'b1;
    rel   = cyc;
    repeat (10) @(posedge clk);
    #1;
    // 10 edges out of reset: mtime=10 during the accepting cycle
    access(0, 1'b0, 16'hBFF8, '0, '0, rd, er);
    check("idle_mtime_lo", 64'(rd), 64'd10);
    check("idle_mti", 64'(mti_pending[0]), 64'd0);
    // k=12 at issue, TICK_DIV=3 -> mtime=4
    access(1, 1'b0, 16'hBFF8, '0, '0, rd, er);
    check("div3_mtime_lo", 64'(rd), 64'd4);

    // mtime restarts at 0; two compare writes later mtime=5
    wr(0, 16'hBFF8, 32'h0, 4'hF);
    wr(0, 16'h4004, 32'h0, 4'hF);
    wr(0, 16'h4000, 32'd20, 4'hF);
    repeat (15) @(posedge clk);
    #1;
    check("cmp20_mti_at_mtime20", 64'(mti_pending[0]), 64'd0);
    @(posedge clk); #1;
    check("cmp20_mti_rise", 64'(mti_pending[0]), 64'd1);

    // wrap: compare first so a huge mtime never transiently matches
    wr(0, 16'h4004, 32'hFFFF_FFFF, 4'hF);
    wr(0, 16'h4000, 32'hFFFF_FFFE, 4'hF);
    wr(0, 16'hBFFC, 32'hFFFF_FFFF, 4'hF);
    wr(0, 16'hBFF8, 32'hFFFF_FFFF, 4'hF);
    check("wrap_mti_high", 64'(mti_pending[0]), 64'd1);
    @(posedge clk); #1;
    check("wrap_mti_clear", 64'(mti_pending[0]), 64'd0);
    access(0, 1'b0, 16'hBFFC, '0, '0, rd, er);
    check("wrap_mtime_hi", 64'(rd), 64'd0);
    access(0, 1'b0, 16'hBFF8, '0, '0, rd, er);
    check("wrap_mtime_lo", 64'(rd), 64'd3);

    wr(0, 16'h4000, 32'h0000_AB00, 4'b0010);
    access(0, 1'b0, 16'h4000, '0, '0, rd, er);
    check("wstrb_cmp_lo", 64'(rd), 64'hFFFF_ABFE);

    access(0, 1'b1, 16'h4005, 32'h0, 4'hF, rd, er);
    check("unaligned_wr_err", 64'(er), 64'd1);
    access(0, 1'b0, 16'h4004, '0, '0, rd, er);
    check("unaligned_wr_nochange", 64'(rd), 64'hFFFF_FFFF);

    // back-to-back erroring reads with req_valid held high
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 16'h0004;
    @(posedge clk); #1;
    check("b2b1_resp_valid", 64'(resp_valid[0]), 64'd1);
    check("b2b1_ready_low",  64'(req_ready[0]),  64'd0);
    check("b2b1_err",        64'(resp_err[0]),   64'd1);
    check("b2b1_rdata",      64'(resp_rdata[0]), 64'd0);
    req_addr[0] = 16'h4002;
    @(posedge clk); #1;
    check("b2b_gap_valid", 64'(resp_valid[0]), 64'd0);
    check("b2b_gap_ready", 64'(req_ready[0]),  64'd1);
    @(posedge clk); #1;
    check("b2b2_resp_valid", 64'(resp_valid[0]), 64'd1);
    check("b2b2_ready_low",  64'(req_ready[0]),  64'd0);
    check("b2b2_err",        64'(resp_err[0]),   64'd1);
    check("b2b2_rdata",      64'(resp_rdata[0]), 64'd0);
    req_valid[0] = 1'b0;
    @(posedge clk); #1;

    access(0, 1'b1, 16'h0000, 32'hFFFF_FFFF, 4'b0001, rd, er);
    check("msip_wr_err", 64'(er), 64'(!MSIP_EN));
    check("msip_pending", 64'(msi_pending[0]), 64'(MSIP_EN));
    access(0, 1'b0, 16'h0000, '0, '0, rd, er);
    check("msip_rd_err",   64'(er), 64'(!MSIP_EN));
    check("msip_rd_rdata", 64'(rd), 64'(MSIP_EN));

    // TICK_DIV=3: a tick is pending in the cycle after edge k when k%3==2
    wr(1, 16'hBFFC, 32'h0000_00A5, 4'hF);
    while (((cyc - rel) % 3) != 2) begin
      @(posedge clk); #1;
    end
    wr(1, 16'hBFF8, 32'h1234_5678, 4'hF);
    access(1, 1'b0, 16'hBFF8, '0, '0, rd, er);
    check("tick_collide_lo", 64'(rd), 64'h1234_5678);
    access(1, 1'b0, 16'hBFFC, '0, '0, rd, er);
    check("tick_collide_hi", 64'(rd), 64'h0000_00A5);

    // reset during a response
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 16'hBFF8;
    @(posedge clk); #1;
    check("midrst_resp_valid", 64'(resp_valid[0]), 64'd1);
    req_valid[0] = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_resp_dropped", 64'(resp_valid[0]), 64'd0);
    check("midrst_ready",        64'(req_ready[0]),  64'd1);
    check("midrst_rdata",        64'(resp_rdata[0]), 64'd0);
    check("midrst_msi",          64'(msi_pending[0]), 64'd0);
    rst_n = 1'b1;
    access(0, 1'b0, 16'hBFF8, '0, '0, rd, er);
    check("midrst_mtime", 64'(rd), 64'd0);
    access(0, 1'b0, 16'h4000, '0, '0, rd, er);
    check("midrst_cmp_lo", 64'(rd), 64'hFFFF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
